// File: rtl/sva_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sva_seq_pkg
// Description : Shared types for the multi-thread sequence tracker
//               (a |-> ##1 b[*0:MAX_REP] ##1 c). Holds the control FSM
//               encoding, the per-slot control record and the pure
//               stage-advance function used by the evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package sva_seq_pkg;

  // Control FSM encoding.
  typedef logic [1:0] ctrl_fsm_t;
  localparam ctrl_fsm_t IDLE  = 2'd0;
  localparam ctrl_fsm_t EVAL  = 2'd1;
  localparam ctrl_fsm_t SPAWN = 2'd2;
  localparam ctrl_fsm_t ABORT = 2'd3;

  // Stage field is sized for the largest supported repetition depth
  // (MAX_REP + 1 <= 255). The start timestamp depends on the TS_W
  // parameter of the tracker, so it lives in a parallel array there.
  localparam int STAGE_W = 8;

  typedef struct packed {
    logic               active;
    logic [STAGE_W-1:0] stage;
  } slot_t;

  typedef struct packed {
    logic [STAGE_W-1:0] nxt;
    logic               succ;
    logic               fail;
  } stage_res_t;

  // Advance one attempt by one sampled edge. c wins over b; a b that
  // would exceed the repetition limit, or neither b nor c, is a failure.
  function automatic stage_res_t next_stage(
    input logic [STAGE_W-1:0] stage,
    input int                 max_rep,
    input logic               b,
    input logic               c
  );
    stage_res_t res;
    res = '0;
    if (c) begin
      res.succ = 1'b1;
    end else if (b && (int'(stage) <= max_rep)) begin
      res.nxt = stage + 1'b1;
    end else begin
      res.fail = 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sva_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : sva_edge_sync
// Description : Two-flop synchronisers for gclk and the sampled signals,
//               gclk rising-edge flag and the per-edge sample latch.
// Ports       : clk, rst       - system clock, synchronous active-high reset
//               i_hold         - tracker busy; an edge seen now is lost
//               i_gclk..i_abort- asynchronous user-domain inputs
//               o_edge         - one-cycle pulse, samples updated this cycle
//               o_lost         - qualifies o_edge: edge arrived while busy
//               o_a..o_abort   - values latched at the last accepted edge
// Revision    : 1.0 - initial release
// ============================================================================
module sva_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_hold,
  input  logic i_gclk,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_abort,
  output logic o_edge,
  output logic o_lost,
  output logic o_a,
  output logic o_b,
  output logic o_c,
  output logic o_abort
);

  logic       r_g_s1;
  logic       r_g_d0;
  logic       r_g_d1;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_smp;
  logic       r_edge;
  logic       r_lost;
  logic       w_edge;

  assign w_edge = r_g_d0 & ~r_g_d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_s1  <= 1'b0;
      r_g_d0  <= 1'b0;
      r_g_d1  <= 1'b0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_smp   <= '0;
      r_edge  <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_g_s1  <= i_gclk;
      r_g_d0  <= r_g_s1;
      r_g_d1  <= r_g_d0;
      r_sync1 <= {i_abort, i_c, i_b, i_a};
      r_sync2 <= r_sync1;
      r_edge  <= w_edge;
      r_lost  <= w_edge & i_hold;
      // Samples of a lost edge must not disturb an evaluation in flight.
      if (w_edge && !i_hold) begin
        r_smp <= r_sync2;
      end
    end
  end

  assign o_edge  = r_edge;
  assign o_lost  = r_lost;
  assign o_a     = r_smp[0];
  assign o_b     = r_smp[1];
  assign o_c     = r_smp[2];
  assign o_abort = r_smp[3];

endmodule
`default_nettype wire

// File: rtl/sva_seq_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sva_seq_tracker
// Description : Multi-thread checker for a |-> ##1 b[*0:MAX_REP] ##1 c,
//               oversampling gclk in the sys_clk domain. Each accepted gclk
//               edge walks every slot once (EVAL), then may spawn one new
//               attempt (SPAWN).
// Ports       : sys_clk, sys_rst - clock, synchronous active-high reset
//               enable           - 0 freezes the FSM and the threads
//               gclk,a,b,c,abort - user-domain inputs, treated as data
//               busy             - FSM in EVAL, SPAWN or ABORT
//               succ,fail,lazy_succ,overflow,edge_miss - 1-cycle pulses
//               succ_latency     - gclk edges from a to c, valid with succ
//               active_cnt       - occupied slots
//               succ_cnt,fail_cnt- saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module sva_seq_tracker
  import sva_seq_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int MAX_REP = 2,
  parameter int TS_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         enable,
  input  logic                         gclk,
  input  logic                         a,
  input  logic                         b,
  input  logic                         c,
  input  logic                         abort,
  output logic                         busy,
  output logic                         succ,
  output logic                         fail,
  output logic                         lazy_succ,
  output logic                         overflow,
  output logic                         edge_miss,
  output logic [TS_W-1:0]              succ_latency,
  output logic [$clog2(THREADS+1)-1:0] active_cnt,
  output logic [CNT_W-1:0]             succ_cnt,
  output logic [CNT_W-1:0]             fail_cnt
);

  localparam int IDX_W = (THREADS > 1) ? $clog2(THREADS) : 1;
  localparam int AW    = $clog2(THREADS + 1);

  ctrl_fsm_t        r_state;
  logic [IDX_W-1:0] r_idx;
  slot_t            r_slots    [THREADS];
  logic [TS_W-1:0]  r_start_ts [THREADS];
  logic [TS_W-1:0]  r_ts;
  logic             r_succ;
  logic             r_fail;
  logic             r_lazy;
  logic             r_ovf;
  logic             r_miss;
  logic [TS_W-1:0]  r_lat;
  logic [AW-1:0]    r_active_cnt;
  logic [CNT_W-1:0] r_succ_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  logic             w_busy;
  logic             w_edge;
  logic             w_lost;
  logic             w_smp_a;
  logic             w_smp_b;
  logic             w_smp_c;
  logic             w_smp_abort;
  slot_t            w_cur;
  stage_res_t       w_res;
  logic [TS_W-1:0]  w_lat;
  logic [AW-1:0]    w_pop;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;

  assign w_busy = (r_state != IDLE);

  sva_edge_sync u_sync (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .i_hold  (w_busy),
    .i_gclk  (gclk),
    .i_a     (a),
    .i_b     (b),
    .i_c     (c),
    .i_abort (abort),
    .o_edge  (w_edge),
    .o_lost  (w_lost),
    .o_a     (w_smp_a),
    .o_b     (w_smp_b),
    .o_c     (w_smp_c),
    .o_abort (w_smp_abort)
  );

  assign w_cur = r_slots[r_idx];
  assign w_res = next_stage(w_cur.stage, MAX_REP, w_smp_b, w_smp_c);
  assign w_lat = r_ts - r_start_ts[r_idx];

  // Occupancy count and lowest-index free slot (scan from the top so the
  // last hit is the lowest index).
  always_comb begin
    w_pop        = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      w_pop = w_pop + AW'(r_slots[i].active);
      if (!r_slots[i].active) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_ts         <= '0;
      r_succ       <= 1'b0;
      r_fail       <= 1'b0;
      r_lazy       <= 1'b0;
      r_ovf        <= 1'b0;
      r_miss       <= 1'b0;
      r_lat        <= '0;
      r_active_cnt <= '0;
      r_succ_cnt   <= '0;
      r_fail_cnt   <= '0;
      for (int i = 0; i < THREADS; i++) begin
        r_slots[i]    <= '0;
        r_start_ts[i] <= '0;
      end
    end else begin
      r_succ       <= 1'b0;
      r_fail       <= 1'b0;
      r_lazy       <= 1'b0;
      r_ovf        <= 1'b0;
      r_miss       <= 1'b0;
      r_active_cnt <= w_pop;

      if (r_succ && (r_succ_cnt != '1)) r_succ_cnt <= r_succ_cnt + 1'b1;
      if (r_fail && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + 1'b1;

      // The timestamp follows every gclk edge, lost ones included, so
      // latencies stay in true gclk edges.
      if (w_edge) begin
        r_ts <= r_ts + 1'b1;
        if (w_lost) r_miss <= 1'b1;
      end

      if (enable) begin
        case (r_state)
          IDLE: begin
            if (w_edge && !w_lost) begin
              if (w_smp_abort) begin
                r_state <= ABORT;
              end else begin
                r_state <= EVAL;
                r_idx   <= '0;
              end
            end
          end
          EVAL: begin
            if (w_cur.active) begin
              if (w_res.succ) begin
                r_succ         <= 1'b1;
                r_lat          <= w_lat;
                r_slots[r_idx] <= '0;
              end else if (w_res.fail) begin
                r_fail         <= 1'b1;
                r_slots[r_idx] <= '0;
              end else begin
                r_slots[r_idx].stage <= w_res.nxt;
              end
            end
            if (r_idx == IDX_W'(THREADS - 1)) begin
              r_state <= SPAWN;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          SPAWN: begin
            // Slots freed during EVAL are already visible here.
            if (!w_smp_a) begin
              r_lazy <= 1'b1;
            end else if (w_free_found) begin
              r_slots[w_free_idx]    <= '{active: 1'b1, stage: STAGE_W'(1)};
              r_start_ts[w_free_idx] <= r_ts;
            end else begin
              r_ovf <= 1'b1;
            end
            r_state <= IDLE;
          end
          ABORT: begin
            for (int i = 0; i < THREADS; i++) begin
              r_slots[i] <= '0;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy         = w_busy;
  assign succ         = r_succ;
  assign fail         = r_fail;
  assign lazy_succ    = r_lazy;
  assign overflow     = r_ovf;
  assign edge_miss    = r_miss;
  assign succ_latency = r_lat;
  assign active_cnt   = r_active_cnt;
  assign succ_cnt     = r_succ_cnt;
  assign fail_cnt     = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sva_seq_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sva_seq_tracker
// Description : Directed self-checking bench. Instance dut uses defaults
//               (THREADS=4, MAX_REP=2); instance dut2 uses THREADS=2 and a
//               2-bit counter so slot overflow and counter saturation are
//               reachable quickly. Both share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sva_seq_tracker;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic enable  = 1'b1;
  logic gclk    = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, abort = 1'b0;

  logic       busy, succ, fail, lazy_succ, overflow, edge_miss;
  logic [7:0] succ_latency;
  logic [2:0] active_cnt;
  logic [15:0] succ_cnt, fail_cnt;

  logic       busy2, succ2, fail2, lazy2, ovf2, miss2;
  logic [7:0] lat2;
  logic [1:0] active2, succ_cnt2, fail_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  int n_succ = 0, n_fail = 0, n_lazy = 0, n_ovf = 0, n_miss = 0;
  int n2_fail = 0, n2_ovf = 0;
  logic [7:0] last_lat = '0;

  always #5 sys_clk = ~sys_clk;

  sva_seq_tracker dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .gclk(gclk),
    .a(a), .b(b), .c(c), .abort(abort),
    .busy(busy), .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
    .overflow(overflow), .edge_miss(edge_miss), .succ_latency(succ_latency),
    .active_cnt(active_cnt), .succ_cnt(succ_cnt), .fail_cnt(fail_cnt)
  );

  sva_seq_tracker #(.THREADS(2), .MAX_REP(2), .TS_W(8), .CNT_W(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .gclk(gclk),
    .a(a), .b(b), .c(c), .abort(abort),
    .busy(busy2), .succ(succ2), .fail(fail2), .lazy_succ(lazy2),
    .overflow(ovf2), .edge_miss(miss2), .succ_latency(lat2),
    .active_cnt(active2), .succ_cnt(succ_cnt2), .fail_cnt(fail_cnt2)
  );

  // Pulse observer: counts single-cycle events away from the active edge.
  always @(negedge sys_clk) begin
    if (succ) begin n_succ++; last_lat = succ_latency; end
    if (fail)      n_fail++;
    if (lazy_succ) n_lazy++;
    if (overflow)  n_ovf++;
    if (edge_miss) n_miss++;
    if (fail2)     n2_fail++;
    if (ovf2)      n2_ovf++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1; gclk = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; abort = 1'b0;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  // One 40-cycle gclk period with the given sampled values.
  task automatic do_edge(input logic ia, input logic ib, input logic ic, input logic iab);
    a = ia; b = ib; c = ic; abort = iab;
    repeat (4) @(negedge sys_clk);
    gclk = 1'b1;
    repeat (20) @(negedge sys_clk);
    gclk = 1'b0;
    repeat (16) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({busy, succ, fail, lazy_succ, overflow, edge_miss} !== 6'b0) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 000000", {busy, succ, fail, lazy_succ, overflow, edge_miss});
    end
    n_cmp++;
    if ({active_cnt, succ_cnt, fail_cnt, succ_latency} !== '0) begin
      n_bad++; $display("FAIL reset_counts: act=%0d sc=%0d fc=%0d lat=%0d want all 0", active_cnt, succ_cnt, fail_cnt, succ_latency);
    end
    n_cmp++;
    if ({busy2, active2, succ_cnt2, fail_cnt2} !== '0) begin
      n_bad++; $display("FAIL reset_dut2: got %b want 0", {busy2, active2, succ_cnt2, fail_cnt2});
    end
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_basic_succ();
    int s_succ, s_lazy;
    do_reset();
    s_succ = n_succ; s_lazy = n_lazy;
    do_edge(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (active_cnt !== 3'd1) begin
      n_bad++; $display("FAIL t1_active_after_a: got %0d want 1", active_cnt);
    end
    do_edge(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (n_succ - s_succ !== 1) begin
      n_bad++; $display("FAIL t1_succ_pulses: got %0d want 1", n_succ - s_succ);
    end
    n_cmp++;
    if (last_lat !== 8'd1) begin
      n_bad++; $display("FAIL t1_latency: got %0d want 1", last_lat);
    end
    n_cmp++;
    if (succ_cnt !== 16'd1 || active_cnt !== 3'd0) begin
      n_bad++; $display("FAIL t1_counts: succ_cnt=%0d active=%0d want 1/0", succ_cnt, active_cnt);
    end
    n_cmp++;
    if (n_lazy - s_lazy !== 1) begin
      n_bad++; $display("FAIL t1_lazy: got %0d want 1", n_lazy - s_lazy);
    end
  endtask

  task automatic test_repeat();
    int s_fail;
    do_reset();
    do_edge(1'b1, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b1, 1'b0, 1'b0);
    do_edge(1'b0, 1'b1, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (succ_cnt !== 16'd1 || last_lat !== 8'd3) begin
      n_bad++; $display("FAIL t2_rep_succ: succ_cnt=%0d lat=%0d want 1/3", succ_cnt, last_lat);
    end
    s_fail = n_fail;
    do_edge(1'b1, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b1, 1'b0, 1'b0);
    do_edge(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (n_fail - s_fail !== 0 || active_cnt !== 3'd1) begin
      n_bad++; $display("FAIL t2_before_limit: fails=%0d active=%0d want 0/1", n_fail - s_fail, active_cnt);
    end
    do_edge(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (n_fail - s_fail !== 1 || fail_cnt !== 16'd1 || active_cnt !== 3'd0) begin
      n_bad++; $display("FAIL t2_over_rep: fails=%0d fail_cnt=%0d active=%0d want 1/1/0", n_fail - s_fail, fail_cnt, active_cnt);
    end
  endtask

  task automatic test_overflow();
    int s_ovf, s_fail;
    do_reset();
    s_ovf = n2_ovf; s_fail = n2_fail;
    do_edge(1'b1, 1'b1, 1'b0, 1'b0);
    do_edge(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (active2 !== 2'd2 || n2_ovf - s_ovf !== 0) begin
      n_bad++; $display("FAIL t3_filled: active=%0d ovf=%0d want 2/0", active2, n2_ovf - s_ovf);
    end
    do_edge(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (n2_ovf - s_ovf !== 1 || active2 !== 2'd2) begin
      n_bad++; $display("FAIL t3_overflow: ovf=%0d active=%0d want 1/2", n2_ovf - s_ovf, active2);
    end
    do_edge(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (n2_fail - s_fail !== 1 || active2 !== 2'd2 || n2_ovf - s_ovf !== 1) begin
      n_bad++; $display("FAIL t3_fail_respawn: fail=%0d active=%0d ovf=%0d want 1/2/1", n2_fail - s_fail, active2, n2_ovf - s_ovf);
    end
  endtask

  task automatic test_lazy();
    int s_lazy, s_succ;
    do_reset();
    s_lazy = n_lazy; s_succ = n_succ;
    do_edge(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (n_lazy - s_lazy !== 1 || n_succ - s_succ !== 0 || succ_cnt !== 16'd0) begin
      n_bad++; $display("FAIL t4_lazy: lazy=%0d succ=%0d succ_cnt=%0d want 1/0/0", n_lazy - s_lazy, n_succ - s_succ, succ_cnt);
    end
  endtask

  task automatic test_abort();
    int s_succ, s_fail, s_lazy;
    int k;
    do_reset();
    do_edge(1'b1, 1'b0, 1'b0, 1'b0);
    do_edge(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (active_cnt !== 3'd2) begin
      n_bad++; $display("FAIL t5_two_active: got %0d want 2", active_cnt);
    end
    s_succ = n_succ; s_fail = n_fail; s_lazy = n_lazy;
    a = 1'b0; b = 1'b0; c = 1'b1; abort = 1'b1;
    repeat (4) @(negedge sys_clk);
    gclk = 1'b1;
    k = 0;
    while (!busy && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (2) @(negedge sys_clk);
    n_cmp++;
    if (k >= 20 || active_cnt !== 3'd0) begin
      n_bad++; $display("FAIL t5_abort_clear: wait=%0d active=%0d want <20/0", k, active_cnt);
    end
    repeat (16) @(negedge sys_clk);
    gclk = 1'b0; abort = 1'b0; c = 1'b0;
    repeat (16) @(negedge sys_clk);
    n_cmp++;
    if (n_succ - s_succ !== 0 || n_fail - s_fail !== 0 || n_lazy - s_lazy !== 0) begin
      n_bad++; $display("FAIL t5_abort_quiet: succ=%0d fail=%0d lazy=%0d want 0/0/0", n_succ - s_succ, n_fail - s_fail, n_lazy - s_lazy);
    end
  endtask

  task automatic test_fast_gclk();
    int s_miss, s_succ;
    int k;
    do_reset();
    s_miss = n_miss; s_succ = n_succ;
    // Spawn, then a second edge 6 cycles later lands while still busy.
    a = 1'b1;
    repeat (4) @(negedge sys_clk);
    gclk = 1'b1; repeat (3) @(negedge sys_clk);
    gclk = 1'b0; a = 1'b0; repeat (3) @(negedge sys_clk);
    gclk = 1'b1; repeat (3) @(negedge sys_clk);
    gclk = 1'b0; repeat (40) @(negedge sys_clk);
    do_edge(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (n_miss - s_miss !== 1) begin
      n_bad++; $display("FAIL t6_one_miss: got %0d want 1", n_miss - s_miss);
    end
    n_cmp++;
    if (n_succ - s_succ !== 1 || last_lat !== 8'd2) begin
      n_bad++; $display("FAIL t6_ts_counts_missed: succ=%0d lat=%0d want 1/2", n_succ - s_succ, last_lat);
    end
    // Ten edges at a 6-cycle period: every second one is lost.
    s_miss = n_miss;
    c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      gclk = 1'b1; repeat (3) @(negedge sys_clk);
      gclk = 1'b0; repeat (3) @(negedge sys_clk);
    end
    repeat (20) @(negedge sys_clk);
    n_cmp++;
    if (n_miss - s_miss !== 5) begin
      n_bad++; $display("FAIL t6_burst_miss: got %0d want 5", n_miss - s_miss);
    end
    // Reset while evaluating.
    a = 1'b1;
    repeat (4) @(negedge sys_clk);
    gclk = 1'b1;
    k = 0;
    while (!busy && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    @(negedge sys_clk);
    sys_rst = 1'b1; gclk = 1'b0; a = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    n_cmp++;
    if (k >= 20 || {busy, succ, fail, lazy_succ, overflow, edge_miss} !== 6'b0 ||
        {active_cnt, succ_cnt, fail_cnt, succ_latency} !== '0) begin
      n_bad++; $display("FAIL t6_mid_eval_reset: wait=%0d busy=%b sc=%0d lat=%0d act=%0d want <20/0/0/0/0", k, busy, succ_cnt, succ_latency, active_cnt);
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_back_to_back_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_edge(1'b1, 1'b0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (succ_cnt !== 16'd4 || last_lat !== 8'd1 || active_cnt !== 3'd1) begin
      n_bad++; $display("FAIL t7_b2b: succ_cnt=%0d lat=%0d active=%0d want 4/1/1", succ_cnt, last_lat, active_cnt);
    end
    n_cmp++;
    if (succ_cnt2 !== 2'd3) begin
      n_bad++; $display("FAIL t7_saturate: got %0d want 3", succ_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_succ();
    test_repeat();
    test_overflow();
    test_lazy();
    test_abort();
    test_fast_gclk();
    test_back_to_back_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
